// File: rtl/alu_core.sv
// Single-stage registered ALU: 4-bit a, 5-bit b, 3-bit opcode.
// Produces a 5-bit result plus carry/borrow and zero flags one edge after sampling.
module alu_core (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] a,
  input  logic [4:0] b,
  input  logic [2:0] command,
  output logic [4:0] sum,
  output logic       carry,
  output logic       zero
);

  localparam logic [2:0] OpZero = 3'b000;
  localparam logic [2:0] OpAdd  = 3'b001;
  localparam logic [2:0] OpSub  = 3'b010;
  localparam logic [2:0] OpAnd  = 3'b011;
  localparam logic [2:0] OpOr   = 3'b100;
  localparam logic [2:0] OpSlt  = 3'b101;
  localparam logic [2:0] OpXor  = 3'b110;
  localparam logic [2:0] OpNot  = 3'b111;

  logic [4:0] ax;
  logic [5:0] add_full;
  logic       a_lt_b;
  logic [4:0] sum_d;
  logic       carry_d;
  logic       zero_d;

  assign ax       = {1'b0, a};
  assign add_full = {1'b0, ax} + {1'b0, b};
  assign a_lt_b   = (ax < b);

  always_comb begin
    sum_d   = 5'd0;
    carry_d = 1'b0;
    unique case (command)
      OpZero: begin
        sum_d   = 5'd0;
        carry_d = 1'b0;
      end
      OpAdd: begin
        sum_d   = add_full[4:0];
        carry_d = add_full[5];
      end
      OpSub: begin
        sum_d   = ax - b;
        carry_d = a_lt_b;
      end
      OpAnd: sum_d = ax & b;
      OpOr:  sum_d = ax | b;
      OpSlt: sum_d = {4'd0, a_lt_b};
      OpXor: sum_d = ax ^ b;
      OpNot: sum_d = ~b;
      default: begin
        sum_d   = 5'd0;
        carry_d = 1'b0;
      end
    endcase
    zero_d = (sum_d == 5'd0);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sum   <= 5'd0;
      carry <= 1'b0;
      zero  <= 1'b1;
    end else begin
      sum   <= sum_d;
      carry <= carry_d;
      zero  <= zero_d;
    end
  end

endmodule

// File: tb/tb_alu_core.sv
// Directed testbench for alu_core: hand-computed vectors checked with immediate assertions.
module tb_alu_core;

  logic       clk;
  logic       rst_n;
  logic [3:0] a;
  logic [4:0] b;
  logic [2:0] command;
  logic [4:0] sum;
  logic       carry;
  logic       zero;

  int checks;
  int failures;

  alu_core dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .a      (a),
    .b      (b),
    .command(command),
    .sum    (sum),
    .carry  (carry),
    .zero   (zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk3(input string tag, input logic [4:0] es, input logic ec, input logic ez);
    chk({tag, ".sum"}, {3'd0, sum}, {3'd0, es});
    chk({tag, ".carry"}, {7'd0, carry}, {7'd0, ec});
    chk({tag, ".zero"}, {7'd0, zero}, {7'd0, ez});
  endtask

  // Apply inputs at negedge, then sample #1 after the following rising edge.
  task automatic step(input logic r, input logic [3:0] av, input logic [4:0] bv,
                      input logic [2:0] cv);
    @(negedge clk);
    rst_n   = r;
    a       = av;
    b       = bv;
    command = cv;
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst_n    = 1'b0;
    a        = 4'd10;
    b        = 5'd1;
    command  = 3'b001;

    // Reset held for two edges with an ADD pending
    step(1'b0, 4'd10, 5'd1, 3'b001);
    chk3("reset_edge1", 5'd0, 1'b0, 1'b1);
    step(1'b0, 4'd10, 5'd1, 3'b001);
    chk3("reset_edge2", 5'd0, 1'b0, 1'b1);
    step(1'b1, 4'd10, 5'd1, 3'b001);
    chk3("reset_release_add", 5'd11, 1'b0, 1'b0);

    // ADD / SUB
    step(1'b1, 4'd10, 5'd1, 3'b010);
    chk3("sub_10_1", 5'd9, 1'b0, 1'b0);
    step(1'b1, 4'd15, 5'd31, 3'b001);
    chk3("add_15_31", 5'd14, 1'b1, 1'b0);
    step(1'b1, 4'd1, 5'd2, 3'b010);
    chk3("sub_1_2", 5'd31, 1'b1, 1'b0);
    step(1'b1, 4'd5, 5'd5, 3'b010);
    chk3("sub_equal", 5'd0, 1'b0, 1'b1);
    step(1'b1, 4'd15, 5'd17, 3'b001);
    chk3("add_wrap_zero", 5'd0, 1'b1, 1'b1);

    // Logic ops with a=1011, b=10101
    step(1'b1, 4'b1011, 5'b10101, 3'b011);
    chk3("and", 5'd1, 1'b0, 1'b0);
    step(1'b1, 4'b1011, 5'b10101, 3'b100);
    chk3("or", 5'd31, 1'b0, 1'b0);
    step(1'b1, 4'b1011, 5'b10101, 3'b110);
    chk3("xor", 5'd30, 1'b0, 1'b0);
    step(1'b1, 4'b1011, 5'b10101, 3'b111);
    chk3("not", 5'd10, 1'b0, 1'b0);
    step(1'b1, 4'd15, 5'b10101, 3'b110);
    chk3("xor_a15", 5'd26, 1'b0, 1'b0);

    // SLT
    step(1'b1, 4'd15, 5'd12, 3'b101);
    chk3("slt_15_12", 5'd0, 1'b0, 1'b1);
    step(1'b1, 4'd12, 5'd15, 3'b101);
    chk3("slt_12_15", 5'd1, 1'b0, 1'b0);
    step(1'b1, 4'd12, 5'd12, 3'b101);
    chk3("slt_12_12", 5'd0, 1'b0, 1'b1);
    step(1'b1, 4'd15, 5'd16, 3'b101);
    chk3("slt_15_16", 5'd1, 1'b0, 1'b0);

    // NOT ignores a; ZERO opcode
    step(1'b1, 4'd12, 5'd21, 3'b111);
    chk3("not_12_21", 5'd10, 1'b0, 1'b0);
    step(1'b1, 4'd15, 5'd31, 3'b000);
    chk3("zero_op", 5'd0, 1'b0, 1'b1);

    // Pipelined sweep with a=6, b=19, glitching inputs between edges
    step(1'b1, 4'd6, 5'd19, 3'b001);
    chk3("pipe_add", 5'd25, 1'b0, 1'b0);
    a = 4'd0; b = 5'd0; command = 3'b000; #2;
    chk3("pipe_glitch_add", 5'd25, 1'b0, 1'b0);
    step(1'b1, 4'd6, 5'd19, 3'b010);
    chk3("pipe_sub", 5'd19, 1'b1, 1'b0);
    a = 4'd15; b = 5'd31; command = 3'b001; #2;
    chk3("pipe_glitch_sub", 5'd19, 1'b1, 1'b0);
    step(1'b1, 4'd6, 5'd19, 3'b011);
    chk3("pipe_and", 5'd2, 1'b0, 1'b0);
    step(1'b1, 4'd6, 5'd19, 3'b100);
    chk3("pipe_or", 5'd23, 1'b0, 1'b0);
    step(1'b1, 4'd6, 5'd19, 3'b101);
    chk3("pipe_slt", 5'd1, 1'b0, 1'b0);
    step(1'b1, 4'd6, 5'd19, 3'b110);
    chk3("pipe_xor", 5'd21, 1'b0, 1'b0);
    step(1'b1, 4'd6, 5'd19, 3'b111);
    chk3("pipe_not", 5'd12, 1'b0, 1'b0);

    // Reset mid-stream overrides a carrying ADD, then current inputs register
    step(1'b0, 4'd15, 5'd31, 3'b001);
    chk3("midreset", 5'd0, 1'b0, 1'b1);
    step(1'b1, 4'd15, 5'd31, 3'b001);
    chk3("midreset_release", 5'd14, 1'b1, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
